// File: rtl/cache_mem_resp_pkg.sv
// Shared transfer-type and FSM state encodings for cache_mem_resp.
// CACHE_RESP_LATENCY_EN adds the RD_WAIT state used for programmable read latency.
package cache_mem_resp_pkg;

    typedef enum logic [2:0] {
        XFER_BYTE = 3'b000,
        XFER_HALF = 3'b001,
        XFER_WORD = 3'b010,
        XFER_LINE = 3'b100
    } xfer_e;

`ifdef CACHE_RESP_LATENCY_EN
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_WAIT  = 2'd1,
        RD_BURST = 2'd2
    } state_e;
`else
    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        RD_BURST = 1'b1
    } state_e;
`endif

    function automatic logic is_line(input logic [2:0] xfer);
        return xfer == XFER_LINE;
    endfunction

endpackage

// File: rtl/cache_mem_resp_mem.sv
// resp_mem: 2^LOG_DEPTH x 32 backing store, one synchronous read port and one
// write port taking either a full 4-word line or one byte-strobed word per cycle.
module resp_mem #(
    parameter int LOG_DEPTH = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rd_en,
    input  logic [LOG_DEPTH-1:0] rd_idx,
    output logic [31:0]          rd_data,
    input  logic                 wr_line,
    input  logic                 wr_word,
    input  logic [LOG_DEPTH-1:0] wr_idx,
    input  logic [3:0]           wr_wstrb,
    input  logic [127:0]         wr_data
);

    logic [31:0] mem [2**LOG_DEPTH];

    // Array has no reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (wr_line) begin
            for (int unsigned k = 0; k < 4; k++) begin
                mem[{wr_idx[LOG_DEPTH-1:2], 2'(k)}] <= wr_data[32*k +: 32];
            end
        end else if (wr_word) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (wr_wstrb[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/cache_mem_resp.sv
// Memory responder for a cache: strobed/line writes, single-word and 4-beat line reads.
// Define CACHE_RESP_LATENCY_EN to insert LAT_CYCLES wait cycles before the first read beat.
module cache_mem_resp
    import cache_mem_resp_pkg::*;
#(
    parameter int LOG_DEPTH  = 10,
    parameter int LAT_CYCLES = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rd_req,
    input  logic [2:0]   rd_type,
    input  logic [31:0]  rd_addr,
    output logic         rd_rdy,
    output logic         ret_valid,
    output logic         ret_last,
    output logic [31:0]  ret_data,
    input  logic         wr_req,
    input  logic [2:0]   wr_type,
    input  logic [31:0]  wr_addr,
    input  logic [3:0]   wr_wstrb,
    input  logic [127:0] wr_data,
    output logic         wr_rdy
);

    state_e               state, state_nxt;
    logic [LOG_DEPTH-1:0] req_word;
    logic                 req_line;
    logic [1:0]           beat;
    logic                 rd_fire, wr_fire;
    logic                 beat_en, beat_last;
    logic [LOG_DEPTH-1:0] rd_idx;
    logic                 unused_addr;

`ifdef CACHE_RESP_LATENCY_EN
    localparam int LW = (LAT_CYCLES > 1) ? $clog2(LAT_CYCLES) : 1;
    localparam logic [LW-1:0] LAT_LOAD = (LAT_CYCLES > 0) ? LW'(LAT_CYCLES - 1) : '0;
    logic [LW-1:0] lat_cnt;
`endif

    assign wr_rdy  = (state == IDLE);
    assign rd_rdy  = (state == IDLE) && !wr_req;
    assign wr_fire = wr_req && wr_rdy;
    assign rd_fire = rd_req && rd_rdy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        beat_en   = 1'b0;
        beat_last = 1'b0;
        case (state)
            IDLE: begin
                if (rd_fire) begin
`ifdef CACHE_RESP_LATENCY_EN
                    state_nxt = (LAT_CYCLES > 0) ? RD_WAIT : RD_BURST;
`else
                    state_nxt = RD_BURST;
`endif
                end
            end
`ifdef CACHE_RESP_LATENCY_EN
            RD_WAIT: begin
                if (lat_cnt == '0) state_nxt = RD_BURST;
            end
`endif
            RD_BURST: begin
                beat_en   = 1'b1;
                beat_last = !req_line || (beat == 2'd3);
                if (beat_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat      <= '0;
            req_word  <= '0;
            req_line  <= 1'b0;
            ret_valid <= 1'b0;
            ret_last  <= 1'b0;
        end else begin
            ret_valid <= beat_en;
            ret_last  <= beat_last;
            if (rd_fire) begin
                req_word <= rd_addr[LOG_DEPTH+1:2];
                req_line <= is_line(rd_type);
                beat     <= '0;
            end else if (beat_en) begin
                beat <= beat_last ? 2'd0 : beat + 2'd1;
            end
        end
    end

`ifdef CACHE_RESP_LATENCY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_cnt <= '0;
        end else if (rd_fire) begin
            lat_cnt <= LAT_LOAD;
        end else if (state == RD_WAIT && lat_cnt != '0) begin
            lat_cnt <= lat_cnt - 1'b1;
        end
    end
`endif

    // Line beats walk the low two word-index bits; the latched offset is discarded.
    assign rd_idx = req_line ? {req_word[LOG_DEPTH-1:2], beat} : req_word;

    assign unused_addr = ^{rd_addr[31:LOG_DEPTH+2], rd_addr[1:0],
                           wr_addr[31:LOG_DEPTH+2], wr_addr[1:0]};

    resp_mem #(
        .LOG_DEPTH(LOG_DEPTH)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .rd_en   (beat_en),
        .rd_idx  (rd_idx),
        .rd_data (ret_data),
        .wr_line (wr_fire && is_line(wr_type)),
        .wr_word (wr_fire && !is_line(wr_type)),
        .wr_idx  (wr_addr[LOG_DEPTH+1:2]),
        .wr_wstrb(wr_wstrb),
        .wr_data (wr_data)
    );

endmodule
